// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default sizing.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam int GATE_CYCLES_DEF = 50_000_000;
    localparam int COUNT_W_DEF     = 26;
    localparam int GATE_W_DEF      = 26;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iAsync,
    output logic oLevel,
    output logic oRise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], iAsync};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign oLevel = sync_q[SYNC_STAGES-1];
    assign oRise  = sync_q[SYNC_STAGES-1] & ~level_d;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of iSig over GATE_CYCLES clocks and publishes
// the saturated count with a one-cycle oValid strobe; windows run back to back.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic               iSig,
    output logic [COUNT_W-1:0] oFreq,
    output logic               oValid,
    output logic               oOvf
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Returns {edge_lost, saturated_count}.
    function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] cnt,
                                                 input logic               inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, cnt} + {{COUNT_W{1'b0}}, inc};
        if (sum[COUNT_W]) begin
            return {1'b1, {COUNT_W{1'b1}}};
        end
        return sum;
    endfunction

    state_t              state;
    state_t              state_next;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic                ovf_flag;
    logic                sig_level;
    logic                sig_rise;
    logic                edge_pulse;
    logic                window_end;
    logic [COUNT_W:0]    sat_res;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAsync (iSig),
        .oLevel (sig_level),
        .oRise  (sig_rise)
    );

    assign edge_pulse = sig_rise & sig_level;
    assign window_end = (state == ST_MEAS) && (gate_cnt == GATE_LAST);
    assign sat_res    = sat_inc(edge_cnt, edge_pulse);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (iEn)  state_next = ST_MEAS;
            ST_MEAS: if (!iEn) state_next = ST_IDLE;
        endcase
    end

    // The window-closing cycle publishes and restarts counting in the same edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            oFreq    <= '0;
            oOvf     <= 1'b0;
            oValid   <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state != ST_MEAS) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end else if (window_end) begin
                oFreq    <= sat_res[COUNT_W-1:0];
                oOvf     <= ovf_flag | sat_res[COUNT_W];
                oValid   <= 1'b1;
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= sat_res[COUNT_W-1:0];
                ovf_flag <= ovf_flag | sat_res[COUNT_W];
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: an 8-bit and a 5-bit counter instance share the same stimulus.
module tb_freq_meter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sig;
    logic [7:0] freq8;
    logic       valid8;
    logic       ovf8;
    logic [4:0] freq5;
    logic       valid5;
    logic       ovf5;

    int checks   = 0;
    int failures = 0;
    int sq_half  = 0;
    int sq_phase = 0;

    freq_meter #(
        .GATE_CYCLES(100), .COUNT_W(8), .GATE_W(8), .SYNC_STAGES(2)
    ) dut8 (
        .iClk(clk), .iRst(rst), .iEn(en), .iSig(sig),
        .oFreq(freq8), .oValid(valid8), .oOvf(ovf8)
    );

    freq_meter #(
        .GATE_CYCLES(100), .COUNT_W(5), .GATE_W(8), .SYNC_STAGES(2)
    ) dut5 (
        .iClk(clk), .iRst(rst), .iEn(en), .iSig(sig),
        .oFreq(freq5), .oValid(valid5), .oOvf(ovf5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave generator: toggles sig every sq_half clocks when sq_half > 0.
    initial begin
        forever begin
            @(negedge clk);
            if (sq_half > 0) begin
                sq_phase++;
                if (sq_phase >= sq_half) begin
                    sig      = ~sig;
                    sq_phase = 0;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic wait_valid(input string tag, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (valid8) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: no oValid within %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1; en = 1'b0; sig = 1'b0; sq_half = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({freq8, valid8, ovf8, freq5, valid5, ovf5} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: freq8=%0d valid8=%0b ovf8=%0b freq5=%0d valid5=%0b ovf5=%0b required all 0",
                     freq8, valid8, ovf8, freq5, valid5, ovf5);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (valid8 || valid5) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_valid: oValid seen=%0b required 0 while iEn=0", seen);
        end
    endtask

    task automatic test_square();
        int n;
        @(negedge clk);
        sq_half = 5;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_valid("first_window", n);
        checks++;
        if (n !== 101) begin
            failures++;
            $display("FAIL first_latency: strobe after %0d edges required 101", n);
        end
        for (int w = 0; w < 3; w++) begin
            wait_valid("square", n);
            checks++;
            if (n !== 100 || freq8 !== 8'd10 || ovf8 !== 1'b0) begin
                failures++;
                $display("FAIL square_w%0d: period=%0d freq=%0d ovf=%0b required 100/10/0",
                         w, n, freq8, ovf8);
            end
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (freq8 !== 8'd10 || valid8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_window_hold: freq=%0d valid=%0b required 10/0", freq8, valid8);
        end
        wait_valid("square_resync", n);
    endtask

    task automatic test_static();
        int n;
        @(negedge clk);
        sq_half = 0;
        sig = 1'b0;
        wait_valid("low_flush", n);
        wait_valid("low", n);
        checks++;
        if (freq8 !== 8'd0) begin
            failures++;
            $display("FAIL static_low: freq=%0d required 0", freq8);
        end
        @(negedge clk);
        sig = 1'b1;
        wait_valid("step", n);
        checks++;
        if (freq8 !== 8'd1) begin
            failures++;
            $display("FAIL step_window: freq=%0d required 1", freq8);
        end
        wait_valid("high", n);
        checks++;
        if (freq8 !== 8'd0) begin
            failures++;
            $display("FAIL static_high: freq=%0d required 0", freq8);
        end
    endtask

    task automatic test_saturate();
        int n;
        @(negedge clk);
        sq_half = 1;
        sq_phase = 0;
        wait_valid("fast_flush", n);
        wait_valid("fast", n);
        checks++;
        if (valid5 !== 1'b1 || freq5 !== 5'd31 || ovf5 !== 1'b1) begin
            failures++;
            $display("FAIL sat5: valid=%0b freq=%0d ovf=%0b required 1/31/1", valid5, freq5, ovf5);
        end
        checks++;
        if (freq8 !== 8'd50 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL nosat8: freq=%0d ovf=%0b required 50/0", freq8, ovf8);
        end
        @(negedge clk);
        sq_half = 5;
        sq_phase = 0;
        wait_valid("slow_flush", n);
        wait_valid("slow", n);
        checks++;
        if (freq5 !== 5'd10 || ovf5 !== 1'b0 || freq8 !== 8'd10 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL recover: freq5=%0d ovf5=%0b freq8=%0d ovf8=%0b required 10/0/10/0",
                     freq5, ovf5, freq8, ovf8);
        end
    endtask

    task automatic test_abort();
        int n;
        bit seen;
        repeat (50) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid8) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || freq8 !== 8'd10) begin
            failures++;
            $display("FAIL abort_hold: valid_seen=%0b freq=%0d required 0/10", seen, freq8);
        end
        @(negedge clk);
        en = 1'b1;
        wait_valid("reentry", n);
        checks++;
        if (n !== 101 || freq8 !== 8'd10) begin
            failures++;
            $display("FAIL reentry: strobe after %0d edges freq=%0d required 101/10", n, freq8);
        end
    endtask

    task automatic test_async_reset();
        int n;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({freq8, valid8, ovf8, freq5, valid5, ovf5} !== '0) begin
            failures++;
            $display("FAIL async_reset: freq8=%0d valid8=%0b ovf8=%0b freq5=%0d required all 0",
                     freq8, valid8, ovf8, freq5);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_valid("post_reset", n);
        checks++;
        if (n !== 101) begin
            failures++;
            $display("FAIL post_reset_latency: strobe after %0d edges required 101", n);
        end
        wait_valid("post_reset2", n);
        checks++;
        if (freq8 !== 8'd10 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_freq: freq=%0d ovf=%0b required 10/0", freq8, ovf8);
        end
    endtask

    task automatic test_boundary();
        int n;
        int sum;
        int exp_a [3];
        int got_a [3];
        int hits;
        bit stray;
        exp_a = '{1, 0, 1};
        @(negedge clk);
        sq_half = 0;
        sig = 1'b0;
        wait_valid("bnd_flush", n);
        wait_valid("bnd_start", n);
        hits = 0;
        stray = 1'b0;
        got_a = '{-1, -1, -1};
        for (int t = 1; t <= 300; t++) begin
            @(posedge clk);
            #1;
            if (valid8) begin
                if (t % 100 == 0) got_a[t / 100 - 1] = int'(freq8);
                else stray = 1'b1;
                hits++;
            end
            @(negedge clk);
            sig = ((t + 1 >= 98) && (t + 1 < 104)) || ((t + 1 >= 199) && (t + 1 < 205));
        end
        checks++;
        if (hits !== 3 || stray !== 1'b0) begin
            failures++;
            $display("FAIL bnd_strobes: count=%0d stray=%0b required 3/0", hits, stray);
        end
        sum = 0;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (got_a[w] !== exp_a[w]) begin
                failures++;
                $display("FAIL bnd_window%0d: freq=%0d required %0d", w, got_a[w], exp_a[w]);
            end
            sum += got_a[w];
        end
        checks++;
        if (sum !== 2) begin
            failures++;
            $display("FAIL bnd_total: sum=%0d required 2", sum);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_static();
        test_saturate();
        test_abort();
        test_async_reset();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
